// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Shared types and helpers for the raster timing generator.
//   timing_t describes one axis (horizontal or vertical) as four region
//   lengths in the order active, front porch, sync, back porch.
//   DEF_* constants give the 640x480@60 mode used as parameter defaults.
package video_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } timing_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int          DEF_CNT_W    = 12;

  // Full period of one axis in pixels or lines.
  function automatic int unsigned total(input timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  // True when cnt falls in [active+fp, active+fp+sync).
  function automatic logic in_sync(input int unsigned cnt, input timing_t t);
    return (cnt >= t.active + t.fp) && (cnt < t.active + t.fp + t.sync);
  endfunction

endpackage

// File: rtl/ce_divider.sv
// ce_divider
//   Pixel clock-enable divider. A phase counter runs 0..CE_DIV-1 while run
//   is high and freezes while run is low, so resuming keeps the phase.
//   Ports:
//     clk_sys  in   system clock
//     reset    in   synchronous, active-high
//     run      in   1 = advance phase, 0 = stall
//     adv      out  combinational: this edge is a pixel advance
//     ce_pix   out  registered copy of adv; high on the cycle the new
//                   pixel position is presented
module ce_divider #(
  parameter int CE_DIV = 1
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic run,
  output logic adv,
  output logic ce_pix
);

  generate
    if (CE_DIV <= 1) begin : g_div1
      // Every running cycle is a pixel; no phase state needed.
      assign adv = run;
    end else begin : g_divn
      localparam int DIV_W = $clog2(CE_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

      logic [DIV_W-1:0] div;

      assign adv = run && (div == DIV_LAST);

      always_ff @(posedge clk_sys) begin
        if (reset)
          div <= '0;
        else if (run)
          div <= (div == DIV_LAST) ? '0 : div + 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge clk_sys) begin
    if (reset)
      ce_pix <= 1'b0;
    else
      ce_pix <= adv;
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Parametrised raster timing generator: pixel clock enable, h/v counters,
//   syncs, blanks, DE and line/frame strobes for the mode set by parameters.
//   Every output is registered from the next-state counters, so the decoded
//   levels always describe the hcount/vcount shown on the same cycle.
//   Optional raster-line interrupt when VTG_LINE_IRQ_EN is defined.
//   Ports:
//     clk_sys      in   system/pixel clock
//     reset        in   synchronous, active-high
//     run          in   1 = timing advances, 0 = stall (levels hold)
//     ce_pix       out  pixel clock enable
//     hcount       out  pixel column 0..H_TOTAL-1
//     vcount       out  line 0..V_TOTAL-1
//     hsync/vsync  out  sync at HS_POL/VS_POL level inside the sync region
//     hblank       out  hcount >= H_ACTIVE
//     vblank       out  vcount >= V_ACTIVE
//     de           out  ~(hblank | vblank)
//     line_start   out  pulse when hcount becomes 0
//     frame_start  out  pulse when (hcount,vcount) becomes (0,0)
//   With VTG_LINE_IRQ_EN:
//     irq_line     in   line to interrupt on
//     irq_ack      in   clears irq
//     irq          out  sticky raster-line interrupt
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int          CE_DIV   = 1,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int          CNT_W    = DEF_CNT_W
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             run,
  output logic             ce_pix,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblank,
  output logic             vblank,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
`ifdef VTG_LINE_IRQ_EN
  ,
  input  logic [CNT_W-1:0] irq_line,
  input  logic             irq_ack,
  output logic             irq
`endif
);

  localparam timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

  localparam int unsigned H_TOTAL = total(H_T);
  localparam int unsigned V_TOTAL = total(V_T);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);

  generate
    if (H_TOTAL > (2 ** CNT_W)) begin : g_h_too_big
      $error("video_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (V_TOTAL > (2 ** CNT_W)) begin : g_v_too_big
      $error("video_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end
    if (CE_DIV < 1) begin : g_bad_div
      $error("video_timing_gen: CE_DIV must be >= 1");
    end
  endgenerate

  // Pixel advance comes from the divider; adv is the edge on which the
  // counters move, ce_pix is the registered marker of that edge.
  logic adv;

  ce_divider #(.CE_DIV(CE_DIV)) u_ce_div (
    .clk_sys (clk_sys),
    .reset   (reset),
    .run     (run),
    .adv     (adv),
    .ce_pix  (ce_pix)
  );

  // Next-state counters; everything registered below decodes these so the
  // level outputs line up with the counters they are registered alongside.
  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;

  always_comb begin
    h_wrap = (hcount == H_LAST);
    v_wrap = (vcount == V_LAST);
    h_nxt  = hcount;
    v_nxt  = vcount;
    if (adv) begin
      if (h_wrap) begin
        h_nxt = '0;
        v_nxt = v_wrap ? '0 : vcount + 1'b1;
      end else begin
        h_nxt = hcount + 1'b1;
      end
    end
  end

  logic line_nxt;
  logic frame_nxt;

  assign line_nxt  = adv && h_wrap;
  assign frame_nxt = adv && h_wrap && v_wrap;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // Park on the last pixel of the frame so the first advance after
      // release lands on (0,0) and raises both strobes.
      hcount      <= H_LAST;
      vcount      <= V_LAST;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hsync       <= in_sync(32'(h_nxt), H_T) ? HS_POL : ~HS_POL;
      vsync       <= in_sync(32'(v_nxt), V_T) ? VS_POL : ~VS_POL;
      hblank      <= (h_nxt >= H_ACT);
      vblank      <= (v_nxt >= V_ACT);
      de          <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      line_start  <= line_nxt;
      frame_start <= frame_nxt;
    end
  end

`ifdef VTG_LINE_IRQ_EN
  // Fires on the line_start edge whose new line matches irq_line. A line
  // number beyond V_TOTAL-1 can never equal v_nxt, so it never fires.
  logic irq_set;

  assign irq_set = line_nxt && (v_nxt == irq_line);

  always_ff @(posedge clk_sys) begin
    if (reset)
      irq <= 1'b0;
    else if (irq_set)
      irq <= 1'b1;          // set beats a simultaneous ack
    else if (irq_ack)
      irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: a small 16x8 mode at CE_DIV=1
// (instance a), the same mode at CE_DIV=4 with positive syncs (instance b)
// and the default 640x480 mode for one line (instance c).
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total_chk = 0;
  int pass_chk  = 0;
  int fail_chk  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_chk++;
    assert (obs === exp) pass_chk++;
    else begin
      fail_chk++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // instance a / b / c signals
  logic a_rst = 1'b1, a_run = 1'b0, a_ce, a_hs, a_vs, a_hb, a_vb, a_de, a_ls, a_fs;
  logic b_rst = 1'b1, b_run = 1'b0, b_ce, b_hs, b_vs, b_hb, b_vb, b_de, b_ls, b_fs;
  logic c_rst = 1'b1, c_run = 1'b0, c_ce, c_hs, c_vs, c_hb, c_vb, c_de, c_ls, c_fs;
  logic [11:0] a_h, a_v, b_h, b_v, c_h, c_v;
`ifdef VTG_LINE_IRQ_EN
  logic [11:0] a_irq_line = 12'd3;
  logic [11:0] bc_irq_line = 12'd0;
  logic a_irq_ack = 1'b0, bc_irq_ack = 1'b0;
  logic a_irq, b_irq, c_irq;
`endif

  video_timing_gen #(.CE_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12)) u_a (
    .clk_sys(clk), .reset(a_rst), .run(a_run), .ce_pix(a_ce), .hcount(a_h), .vcount(a_v),
    .hsync(a_hs), .vsync(a_vs), .hblank(a_hb), .vblank(a_vb), .de(a_de),
    .line_start(a_ls), .frame_start(a_fs)
`ifdef VTG_LINE_IRQ_EN
    , .irq_line(a_irq_line), .irq_ack(a_irq_ack), .irq(a_irq)
`endif
  );

  video_timing_gen #(.CE_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(12)) u_b (
    .clk_sys(clk), .reset(b_rst), .run(b_run), .ce_pix(b_ce), .hcount(b_h), .vcount(b_v),
    .hsync(b_hs), .vsync(b_vs), .hblank(b_hb), .vblank(b_vb), .de(b_de),
    .line_start(b_ls), .frame_start(b_fs)
`ifdef VTG_LINE_IRQ_EN
    , .irq_line(bc_irq_line), .irq_ack(bc_irq_ack), .irq(b_irq)
`endif
  );

  video_timing_gen u_c (
    .clk_sys(clk), .reset(c_rst), .run(c_run), .ce_pix(c_ce), .hcount(c_h), .vcount(c_v),
    .hsync(c_hs), .vsync(c_vs), .hblank(c_hb), .vblank(c_vb), .de(c_de),
    .line_start(c_ls), .frame_start(c_fs)
`ifdef VTG_LINE_IRQ_EN
    , .irq_line(bc_irq_line), .irq_ack(bc_irq_ack), .irq(c_irq)
`endif
  );

  initial begin
    logic [11:0] eh, ev;
    int cnt, dec, first, hs_cnt;
    logic stalled, ok;

    repeat (3) tick();

    // ---- reset state of all three instances
    check("a_reset", {a_h, a_v, a_ce, a_de, a_hb, a_vb, a_hs, a_vs, a_ls, a_fs},
                     {12'd15, 12'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    check("b_reset", {b_h, b_v, b_ce, b_de, b_hs, b_vs}, {12'd15, 12'd7, 1'b0, 1'b0, 1'b0, 1'b0});
    check("c_reset", {c_h, c_v, c_ce, c_de, c_hb, c_vb, c_hs, c_vs},
                     {12'd799, 12'd524, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});

    // ---- a: one full frame, CE_DIV=1
    a_rst = 1'b0; a_run = 1'b1;
    tick();
    eh = 12'd0; ev = 12'd0; dec = 0;
    for (int i = 0; i < 128; i++) begin
      check("a_frame", {a_h, a_v, a_ce, a_hs, a_vs, a_hb, a_vb, a_de, a_ls, a_fs},
        {eh, ev, 1'b1, !(eh >= 10 && eh <= 12), !(ev >= 5 && ev <= 6), eh >= 8, ev >= 4,
         (eh < 8 && ev < 4), eh == 0, (eh == 0 && ev == 0)});
      if (a_de) dec++;
      tick();
      if (eh == 12'd15) begin
        eh = 12'd0;
        ev = (ev == 12'd7) ? 12'd0 : ev + 12'd1;
      end else eh = eh + 12'd1;
    end
    check("a_frame_wrap", {a_h, a_v, a_fs, a_ls}, {12'd0, 12'd0, 1'b1, 1'b1});
    check("a_de_count", 64'(dec), 64'd32);

    // ---- a: stall 10 clk at hcount 5, line measures 26 clk
    cnt = 0; stalled = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick(); cnt++;
      if (a_ls) break;
      if (a_h == 12'd5 && !stalled) begin
        stalled = 1'b1; a_run = 1'b0;
        repeat (10) begin
          tick(); cnt++;
          check("a_stall", {a_h, a_ce, a_ls, a_fs, a_hs, a_de},
                           {12'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        end
        a_run = 1'b1;
      end
    end
    check("a_stall_line_len", 64'(cnt), 64'd26);
    check("a_stall_next_line", {a_h, a_v, a_ls}, {12'd0, 12'd1, 1'b1});

    // ---- a: reset mid-frame at (3,2)
    for (int i = 0; i < 40 && !(a_h == 12'd3 && a_v == 12'd2); i++) tick();
    check("a_reach_3_2", {a_h, a_v}, {12'd3, 12'd2});
    a_rst = 1'b1;
    tick();
    check("a_midreset", {a_h, a_v, a_ce, a_de, a_hb, a_vb, a_hs, a_vs, a_ls, a_fs},
                        {12'd15, 12'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    tick(); tick();
    a_rst = 1'b0;
    tick();
    check("a_after_reset", {a_h, a_v, a_ce, a_fs, a_ls}, {12'd0, 12'd0, 1'b1, 1'b1, 1'b1});

`ifdef VTG_LINE_IRQ_EN
    // ---- a: raster interrupt on line 3
    check("irq_idle", 64'(a_irq), 64'd0);
    for (int i = 0; i < 60 && !(a_h == 12'd15 && a_v == 12'd2); i++) tick();
    check("irq_before", {a_h, a_v, a_irq}, {12'd15, 12'd2, 1'b0});
    a_irq_ack = 1'b1;
    tick();
    a_irq_ack = 1'b0;
    check("irq_set_wins", {a_irq, a_ls, a_v}, {1'b1, 1'b1, 12'd3});
    tick(); tick();
    check("irq_sticky", 64'(a_irq), 64'd1);
    a_irq_ack = 1'b1;
    tick();
    a_irq_ack = 1'b0;
    check("irq_ack_clear", 64'(a_irq), 64'd0);
    a_irq_line = 12'd8;
    ok = 1'b1;
    for (int i = 0; i < 140; i++) begin
      tick();
      if (a_irq) ok = 1'b0;
    end
    check("irq_out_of_range", 64'(ok), 64'd1);
`endif

    // ---- b: CE_DIV=4, positive syncs
    b_rst = 1'b0; b_run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_first_phase", {b_ce, b_h}, {1'b0, 12'd15});
    end
    tick();
    check("b_first_pix", {b_ce, b_h, b_v, b_fs, b_ls}, {1'b1, 12'd0, 12'd0, 1'b1, 1'b1});
    eh = 12'd0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (i % 4 == 3) eh = (eh == 12'd15) ? 12'd0 : eh + 12'd1;
      check("b_line", {b_ce, b_h, b_hs, b_vs},
                      {(i % 4 == 3), eh, (eh >= 10 && eh <= 12), 1'b0});
    end
    check("b_line_len", {b_h, b_v, b_ls}, {12'd0, 12'd1, 1'b1});

    // ---- c: default 640x480 mode, one line
    c_rst = 1'b0; c_run = 1'b1;
    tick();
    check("c_first_pix", {c_h, c_v, c_fs, c_ls, c_de}, {12'd0, 12'd0, 1'b1, 1'b1, 1'b1});
    first = -1; hs_cnt = 0; dec = 0;
    for (int i = 0; i < 800; i++) begin
      if (!c_hs) begin
        if (first < 0) first = int'(c_h);
        hs_cnt++;
      end
      if (c_de) dec++;
      tick();
    end
    check("c_hsync_start", 64'(first), 64'd656);
    check("c_hsync_width", 64'(hs_cnt), 64'd96);
    check("c_de_per_line", 64'(dec), 64'd640);
    check("c_line_len", {c_h, c_v, c_ls, c_vs}, {12'd0, 12'd1, 1'b1, 1'b1});

    $display("%0d/%0d checks passed", pass_chk, total_chk);
    $finish;
  end

endmodule
